clk_div_ctrl: RTL
=================

# clk_div_ctrl

Runtime-programmable clock-divider controller for the lab clock tree. Two requesters (A, B) submit divide ratios over valid/ready handshakes. A round-robin arbiter grants one request at a time. An FSM applies the granted ratio only at an output-period boundary, so `clk_out` never glitches or produces a truncated period. The block also emits a one-cycle `strobe` at the start of every output period, for downstream strobe counters.

## Interface
- `WIDTH`, default 8: width of the divide ratio and of the internal counter.
- `DEFAULT_DIV`, default 4: ratio loaded at reset. Must be ≥2.
- `clk_in` input 1: single system clock; all logic runs on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `enable` input 1: run/stop for the divided output.
- `req_a_valid` input 1: requester A has a ratio pending.
- `req_a_div` input WIDTH: requester A ratio. Held stable while valid.
- `req_a_ready` output 1: A transfer accepted this cycle.
- `req_b_valid`, `req_b_div`, `req_b_ready`: same as A, for requester B.
- `err_clr` input 1: clears `err`.
- `clk_out` output 1: divided clock, registered.
- `strobe` output 1: registered one-cycle pulse at the first cycle of each period.
- `cur_div` output WIDTH: ratio currently in effect.
- `owner` output 1: last granted requester (0=A, 1=B).
- `busy` output 1: a legal ratio is pending application.
- `err` output 1: sticky flag; an illegal ratio was received.

## Operation
- **Reset values:**
  - `cur_div`=DEFAULT_DIV; counter `cnt`=all-ones.
  - `clk_out`=0, `strobe`=0, `busy`=0, `err`=0.
  - `owner`=1, so A wins the first tie.
  - FSM in IDLE; pending ratio register cleared.
- **Wrap condition:** `cnt` ≥ `cur_div`−1. Using ≥ keeps the all-ones reset value and ratio shrinks safe.
- **enable=1, each edge:**
  - `cnt` ← 0 on wrap, else `cnt`+1.
  - `clk_out` ← (new `cnt` < `cur_div`>>1).
  - `strobe` ← (new `cnt` == 0).
- **Resulting waveform:** period N cycles; high for floor(N/2) cycles, then low for ceil(N/2) cycles.
- **enable=0:** `cnt` ← all-ones, `clk_out` ← 0, `strobe` ← 0. The first enabled edge starts a fresh period with `strobe`=1.
- **Arbitration (IDLE only):**
  - Only one valid: grant it.
  - Both valid: grant the requester that is not `owner`.
  - `req_x_ready` = (state==IDLE) & grant_x. This is combinational; no ready is asserted outside IDLE.
  - Transfer occurs on valid & ready; `owner` updates at that edge.
- **Legality:** a ratio in 2..2^WIDTH−1 is legal.
  - Ratio 0 or 1: the transfer still completes (ready asserted), the value is discarded, `err` ← 1, and the FSM stays in IDLE.
  - `err_clr` clears `err`. If `err_clr` coincides with a new illegal transfer, the set wins.
- **FSM states:**
  - IDLE → PENDING on a legal transfer: pending ← ratio, `busy`=1.
  - PENDING, enable=1: stay until an edge where the wrap condition holds. At that edge:
    - `cur_div` ← pending, `cnt` ← 0, `clk_out` ← 1, `strobe` ← 1.
    - FSM → IDLE.
  - PENDING, enable=0: at the next edge `cur_div` ← pending, FSM → IDLE. `clk_out` stays 0.
- **Same-value request:** a request equal to `cur_div` takes the normal PENDING path; there is no shortcut.
- **Mid-operation reset:** an asynchronous `rst` assertion discards any pending ratio and forces all reset values immediately.

## Timing
- **Handshake:** ready is combinational on the same cycle as valid when IDLE.
- **Acceptance:** `busy` rises the cycle after the transfer.
- **Application latency:** 1 to `cur_div` cycles after acceptance.
  - A wrap on the acceptance edge itself does not apply the change. The change waits for the next wrap, so the latency is a full period.
- **Back-to-back requests:** minimum spacing between accepted requests is 2 cycles (accept, then apply, then IDLE).
- **Output alignment:** `clk_out`, `strobe` and `cur_div` change on the same edge when a new ratio is applied.
- **Combinational paths:** none from inputs to outputs except `req_x_ready`.

## Test plan
- **Default running:** release `rst`, hold enable=1.
  - `clk_out` = 1,1,0,0 repeating; `strobe` every 4th cycle, aligned with the first high cycle; `cur_div`=4.
- **Mid-period ratio change:** A requests 5 at `cnt`=1.
  - `req_a_ready`=1 that cycle; `busy`=1 for 2 cycles.
  - The current 4-cycle period finishes intact.
  - Then `clk_out` = 1,1,0,0,0 repeating, with `strobe` every 5 cycles; `owner`=0.
- **Tie after reset:** A=6 and B=3 valid together.
  - A is granted first.
  - After 6 is applied, B gets ready in IDLE and 3 is applied at the next wrap; `owner`=1.
  - Then both valid again with `owner`=1: A is granted.
- **Illegal ratio:** request 1.
  - Ready asserted, `err`=1, `busy` stays 0, `cur_div` unchanged.
  - `err_clr` pulse → `err`=0.
- **Reset mid-PENDING:** A requests 200 while `cur_div`=4, then `rst` low for 1 cycle.
  - All outputs at reset values, pending ratio lost.
  - After release, period is 4.
- **Enable low during PENDING:** enable=0 with ratio 8 pending.
  - `cur_div`=8 next edge, `clk_out`=0.
  - When enable returns to 1: `strobe` on the first edge, then 4 cycles high and 4 cycles low.

Source files
------------

// File: rtl/clk_div_ctrl.sv
// -----------------------------------------------------------------------------
// clk_div_ctrl
//
// Runtime-programmable clock divider for the lab clock tree. Two requesters
// (A, B) offer new divide ratios over valid/ready handshakes; a round-robin
// arbiter accepts one at a time. An accepted ratio is held pending and only
// applied at an output-period boundary, so clk_out never glitches or emits a
// truncated period. A one-cycle strobe marks the first cycle of each period.
//
// Parameters
//   WIDTH        width of the divide ratio and of the period counter
//   DEFAULT_DIV  ratio in effect after reset (must be >= 2)
//
// Ports
//   clk_in       system clock, all logic on its rising edge
//   rst          asynchronous active-low reset
//   enable       run/stop for the divided output
//   req_a_valid  requester A has a ratio pending
//   req_a_div    requester A ratio (stable while valid)
//   req_a_ready  A transfer accepted this cycle (combinational)
//   req_b_valid  requester B has a ratio pending
//   req_b_div    requester B ratio (stable while valid)
//   req_b_ready  B transfer accepted this cycle (combinational)
//   err_clr      clears err
//   clk_out      divided clock (registered)
//   strobe       one-cycle pulse on the first cycle of each period
//   cur_div      ratio currently in effect
//   owner        last granted requester (0=A, 1=B)
//   busy         a legal ratio is waiting to be applied
//   err          sticky: an illegal ratio (0 or 1) was received
// -----------------------------------------------------------------------------
module clk_div_ctrl #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_DIV = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             enable,
    input  logic             req_a_valid,
    input  logic [WIDTH-1:0] req_a_div,
    output logic             req_a_ready,
    input  logic             req_b_valid,
    input  logic [WIDTH-1:0] req_b_div,
    output logic             req_b_ready,
    input  logic             err_clr,
    output logic             clk_out,
    output logic             strobe,
    output logic [WIDTH-1:0] cur_div,
    output logic             owner,
    output logic             busy,
    output logic             err
);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_PENDING = 1'b1
    } state_t;

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] DEF_DIV  = WIDTH'(DEFAULT_DIV);

    state_t           r_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] r_cur_div;
    logic [WIDTH-1:0] r_pending;
    logic             r_clk_out;
    logic             r_strobe;
    logic             r_owner;
    logic             r_busy;
    logic             r_err;

    logic             w_wrap;
    logic [WIDTH-1:0] w_cnt_next;
    logic [WIDTH-1:0] w_half;
    logic             w_grant_a;
    logic             w_grant_b;
    logic             w_xfer;
    logic [WIDTH-1:0] w_sel_div;
    logic             w_legal;

    // ">=" rather than "==" so the all-ones idle count, and any count left
    // beyond a smaller ratio, always ends the period on the next edge.
    assign w_wrap     = (r_cnt >= (r_cur_div - 1'b1));
    assign w_cnt_next = w_wrap ? '0 : (r_cnt + 1'b1);
    assign w_half     = r_cur_div >> 1;

    // Round robin: on a tie the requester that did not win last time goes.
    assign w_grant_a = req_a_valid & (~req_b_valid | r_owner);
    assign w_grant_b = req_b_valid & (~req_a_valid | ~r_owner);

    assign req_a_ready = (r_state == S_IDLE) & w_grant_a;
    assign req_b_ready = (r_state == S_IDLE) & w_grant_b;

    assign w_xfer    = req_a_ready | req_b_ready;
    assign w_sel_div = w_grant_a ? req_a_div : req_b_div;
    assign w_legal   = (w_sel_div > WIDTH'(1));

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= ALL_ONES;
            r_cur_div <= DEF_DIV;
            r_pending <= '0;
            r_clk_out <= 1'b0;
            r_strobe  <= 1'b0;
            r_owner   <= 1'b1;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            // Divider datapath, including application of a pending ratio.
            if (r_state == S_PENDING && !enable) begin
                // Output is stopped, so there is no period to protect.
                r_cur_div <= r_pending;
                r_cnt     <= ALL_ONES;
                r_clk_out <= 1'b0;
                r_strobe  <= 1'b0;
            end else if (r_state == S_PENDING && w_wrap) begin
                // Period boundary: start the first period at the new ratio.
                r_cur_div <= r_pending;
                r_cnt     <= '0;
                r_clk_out <= 1'b1;
                r_strobe  <= 1'b1;
            end else if (enable) begin
                r_cnt     <= w_cnt_next;
                r_clk_out <= (w_cnt_next < w_half);
                r_strobe  <= (w_cnt_next == '0);
            end else begin
                r_cnt     <= ALL_ONES;
                r_clk_out <= 1'b0;
                r_strobe  <= 1'b0;
            end

            // Control FSM. A wrap on the acceptance edge is seen in IDLE and
            // therefore does not apply the new ratio.
            case (r_state)
                S_IDLE: begin
                    if (w_xfer) begin
                        r_owner <= w_grant_b;
                        if (w_legal) begin
                            r_pending <= w_sel_div;
                            r_state   <= S_PENDING;
                            r_busy    <= 1'b1;
                        end
                    end
                end
                S_PENDING: begin
                    if (!enable || w_wrap) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase

            // Sticky error; a new illegal transfer beats a simultaneous clear.
            if (w_xfer && !w_legal) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end
        end
    end

    assign clk_out = r_clk_out;
    assign strobe  = r_strobe;
    assign cur_div = r_cur_div;
    assign owner   = r_owner;
    assign busy    = r_busy;
    assign err     = r_err;

endmodule
